// File: rtl/fmap_pingpong_ctrl.sv
// Ping-pong feature-map buffer controller.
// The producer fills one bank while the consumer drains the other. The banks
// swap when the write bank is full and the read bank is empty.
// Handshake contract: an element moves on a side only in a cycle where both
// valid and ready are high. valid is never withdrawn while ready is low. Data
// is held stable while the element is stalled.
module fmap_pingpong_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int WRITE_H    = 64,
  parameter int WRITE_W    = 64,
  parameter int WRITE_C    = 16,
  parameter int READ_H     = 64,
  parameter int READ_W     = 64,
  parameter int READ_C     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [3:0]            write_ch,
  output logic [5:0]            write_h,
  output logic [5:0]            write_w,
  output logic                  read_en,
  output logic [3:0]            read_ch,
  output logic [5:0]            read_h,
  output logic [5:0]            read_w,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  mode_sel,
  output logic                  swap_pulse,
  output logic                  dbg_wr_full,
  output logic                  dbg_rd_full
);

  localparam logic [3:0] WC_MAX = 4'(WRITE_C - 1);
  localparam logic [5:0] WH_MAX = 6'(WRITE_H - 1);
  localparam logic [5:0] WW_MAX = 6'(WRITE_W - 1);
  localparam logic [3:0] RC_MAX = 4'(READ_C - 1);
  localparam logic [5:0] RH_MAX = 6'(READ_H - 1);
  localparam logic [5:0] RW_MAX = 6'(READ_W - 1);

  logic [3:0] r_wr_ch;
  logic [5:0] r_wr_h;
  logic [5:0] r_wr_w;
  logic [3:0] r_rd_ch;
  logic [5:0] r_rd_h;
  logic [5:0] r_rd_w;
  logic       r_wr_full;
  logic       r_rd_full;
  logic       r_mode;
  logic       r_swap_pulse;
  logic       r_out_valid;
  logic       r_out_last;

  logic w_write_en;
  logic w_read_en;
  logic w_wr_last;
  logic w_rd_last;
  logic w_swap;

  // Handshake strobes. Both are gated by rst so the buffer is never touched during reset.
  assign in_ready   = !r_wr_full && !rst;
  assign w_write_en = in_valid && in_ready;
  assign w_read_en  = r_rd_full && (!r_out_valid || out_ready) && !rst;
  assign w_wr_last  = (r_wr_ch == WC_MAX) && (r_wr_h == WH_MAX) && (r_wr_w == WW_MAX);
  assign w_rd_last  = (r_rd_ch == RC_MAX) && (r_rd_h == RH_MAX) && (r_rd_w == RW_MAX);
  assign w_swap     = r_wr_full && !r_rd_full;

  assign write_en    = w_write_en;
  assign data_in     = in_data;
  assign write_ch    = r_wr_ch;
  assign write_h     = r_wr_h;
  assign write_w     = r_wr_w;
  assign read_en     = w_read_en;
  assign read_ch     = r_rd_ch;
  assign read_h      = r_rd_h;
  assign read_w      = r_rd_w;
  assign out_valid   = r_out_valid;
  assign out_data    = buf_data;
  assign out_last    = r_out_last;
  assign mode_sel    = r_mode;
  assign swap_pulse  = r_swap_pulse;
  assign dbg_wr_full = r_wr_full;
  assign dbg_rd_full = r_rd_full;

  // Write-side scan counters: w innermost, then h, then ch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ch <= '0;
      r_wr_h  <= '0;
      r_wr_w  <= '0;
    end else if (w_write_en) begin
      if (w_wr_last) begin
        r_wr_ch <= '0;
        r_wr_h  <= '0;
        r_wr_w  <= '0;
      end else if (r_wr_w == WW_MAX) begin
        r_wr_w <= '0;
        if (r_wr_h == WH_MAX) begin
          r_wr_h  <= '0;
          r_wr_ch <= r_wr_ch + 4'd1;
        end else begin
          r_wr_h <= r_wr_h + 6'd1;
        end
      end else begin
        r_wr_w <= r_wr_w + 6'd1;
      end
    end
  end

  // Read-side scan counters, same order as the write side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ch <= '0;
      r_rd_h  <= '0;
      r_rd_w  <= '0;
    end else if (w_read_en) begin
      if (w_rd_last) begin
        r_rd_ch <= '0;
        r_rd_h  <= '0;
        r_rd_w  <= '0;
      end else if (r_rd_w == RW_MAX) begin
        r_rd_w <= '0;
        if (r_rd_h == RH_MAX) begin
          r_rd_h  <= '0;
          r_rd_ch <= r_rd_ch + 4'd1;
        end else begin
          r_rd_h <= r_rd_h + 6'd1;
        end
      end else begin
        r_rd_w <= r_rd_w + 6'd1;
      end
    end
  end

  // Bank occupancy and swap. Swap only needs wr_full, while a write needs
  // !wr_full, so setting and clearing the same flag on one edge cannot
  // collide. The rd_full flag follows the same rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_full    <= 1'b0;
      r_rd_full    <= 1'b0;
      r_mode       <= 1'b0;
      r_swap_pulse <= 1'b0;
    end else begin
      r_swap_pulse <= w_swap;
      if (w_swap) begin
        r_mode    <= ~r_mode;
        r_wr_full <= 1'b0;
        r_rd_full <= 1'b1;
      end else begin
        if (w_write_en && w_wr_last) r_wr_full <= 1'b1;
        if (w_read_en && w_rd_last)  r_rd_full <= 1'b0;
      end
    end
  end

  // Output stage: valid and last follow the buffer's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_read_en) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_rd_last;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_ctrl.sv
// Directed bench for fmap_pingpong_ctrl with a 2x2x1 frame (4 elements).
// It includes a two-bank registered-read buffer model and a scoreboard of
// accepted producer elements.
`timescale 1ns/1ps
module tb_fmap_pingpong_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          write_en;
  logic [DW-1:0] data_in;
  logic [3:0]    write_ch;
  logic [5:0]    write_h;
  logic [5:0]    write_w;
  logic          read_en;
  logic [3:0]    read_ch;
  logic [5:0]    read_h;
  logic [5:0]    read_w;
  logic [DW-1:0] buf_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          mode_sel;
  logic          swap_pulse;
  logic          dbg_wr_full;
  logic          dbg_rd_full;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  fmap_pingpong_ctrl #(
    .DATA_WIDTH(DW), .WRITE_H(2), .WRITE_W(2), .WRITE_C(1),
    .READ_H(2), .READ_W(2), .READ_C(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_en(write_en), .data_in(data_in), .write_ch(write_ch), .write_h(write_h),
    .write_w(write_w), .read_en(read_en), .read_ch(read_ch), .read_h(read_h),
    .read_w(read_w), .buf_data(buf_data), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .mode_sel(mode_sel),
    .swap_pulse(swap_pulse), .dbg_wr_full(dbg_wr_full), .dbg_rd_full(dbg_rd_full)
  );

  // Two-bank buffer: mode 0 writes bank 0 and reads bank 1. Read data is registered.
  logic [DW-1:0] mem [0:1][0:15];
  always @(posedge clk) begin
    int widx;
    int ridx;
    widx = int'(write_ch) * 4 + int'(write_h) * 2 + int'(write_w);
    ridx = int'(read_ch) * 4 + int'(read_h) * 2 + int'(read_w);
    if (write_en && widx < 16) mem[mode_sel ? 1 : 0][widx] <= data_in;
    if (read_en) buf_data <= (ridx < 16) ? mem[mode_sel ? 0 : 1][ridx] : '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / protocol monitor, sampled mid-cycle
  logic          prev_mode = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int            rd_idx = 0;
  int            swap_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_mode  = 1'b0;
      stall_prev = 1'b0;
      rd_idx     = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, stall_data});
      end
      check("read_in_stall", {31'd0, out_valid && !out_ready && read_en}, 32'd0);
      if (swap_pulse) begin
        swap_cnt++;
        check("swap_toggle", {31'd0, mode_sel}, {31'd0, ~prev_mode});
      end else begin
        check("mode_hold", {31'd0, mode_sel}, {31'd0, prev_mode});
      end
      prev_mode = mode_sel;
      if (write_en) exp_q.push_back(in_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
          check("out_last", {31'd0, out_last}, {31'd0, rd_idx == 3});
          rd_idx = (rd_idx + 1) % 4;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        accepted = 1'b1;
        break;
      end
      step();
    end
    check("push_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic drain(input logic [3:0] pat, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      out_ready = pat[3 - (i % 4)];
      step();
      if (exp_q.size() == 0 && !out_valid && !dbg_rd_full && !dbg_wr_full) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", {31'd0, done}, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int swaps0;
    logic m;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) step();
    // Reset state. in_valid is high to show the write strobe is gated.
    in_valid = 1'b1;
    #1;
    check("rst_write_en", {31'd0, write_en}, 32'd0);
    check("rst_read_en", {31'd0, read_en}, 32'd0);
    check("rst_mode", {31'd0, mode_sel}, 32'd0);
    check("rst_swap", {31'd0, swap_pulse}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_flags", {30'd0, dbg_wr_full, dbg_rd_full}, 32'd0);
    check("rst_wcoord", {16'd0, write_ch, write_h, write_w}, 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Single frame 0x10..0x13.
    push(8'h10);
    check("wcoord_1", {16'd0, write_ch, write_h, write_w}, {16'd0, 4'd0, 6'd0, 6'd1});
    push(8'h11);
    check("wcoord_2", {16'd0, write_ch, write_h, write_w}, {16'd0, 4'd0, 6'd1, 6'd0});
    push(8'h12);
    push(8'h13);
    in_valid = 1'b0;
    check("f1_wr_full", {31'd0, dbg_wr_full}, 32'd1);
    check("f1_in_ready", {31'd0, in_ready}, 32'd0);
    check("f1_mode_pre", {31'd0, mode_sel}, 32'd0);
    check("f1_wcoord_wrap", {16'd0, write_ch, write_h, write_w}, 32'd0);
    check("f1_swap_pre", {31'd0, swap_pulse}, 32'd0);
    step();
    check("f1_swap", {31'd0, swap_pulse}, 32'd1);
    check("f1_mode", {31'd0, mode_sel}, 32'd1);
    check("f1_flags", {30'd0, dbg_wr_full, dbg_rd_full}, 32'd1);
    check("f1_read_en", {31'd0, read_en}, 32'd1);
    check("f1_rcoord0", {16'd0, read_ch, read_h, read_w}, 32'd0);
    step();
    check("f1_out_valid", {31'd0, out_valid}, 32'd1);
    check("f1_out_data0", {24'd0, out_data}, 32'h10);
    check("f1_swap_end", {31'd0, swap_pulse}, 32'd0);
    check("f1_rcoord1", {26'd0, read_w}, 32'd1);
    drain(4'b1111, 100);
    check("f1_mode_end", {31'd0, mode_sel}, 32'd1);

    // Producer blocked: two frames written while the consumer is stalled.
    out_ready = 1'b0;
    push(8'h20); push(8'h21); push(8'h22); push(8'h23);
    push(8'h30); push(8'h31); push(8'h32); push(8'h33);
    in_valid = 1'b0;
    check("blk_wr_full", {31'd0, dbg_wr_full}, 32'd1);
    check("blk_in_ready", {31'd0, in_ready}, 32'd0);
    m = mode_sel;
    repeat (6) step();
    check("blk_no_swap", {31'd0, mode_sel}, {31'd0, m});
    check("blk_in_ready_hold", {31'd0, in_ready}, 32'd0);
    check("blk_out_valid", {31'd0, out_valid}, 32'd1);
    check("blk_out_data", {24'd0, out_data}, 32'h20);
    check("blk_read_en", {31'd0, read_en}, 32'd0);
    // Consumer stall pattern 1,0,0,1 drains both frames.
    drain(4'b1001, 300);
    check("blk_mode_end", {31'd0, mode_sel}, 32'd1);

    // Back-to-back streaming of three frames.
    swaps0 = swap_cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) push(8'(8'h40 + k));
    in_valid = 1'b0;
    drain(4'b1111, 200);
    check("stream_swaps", 32'(swap_cnt - swaps0), 32'd3);
    check("stream_mode_end", {31'd0, mode_sel}, 32'd0);

    // Async reset after two writes of a partial frame.
    push(8'h50);
    push(8'h51);
    check("part_wcoord", {16'd0, write_ch, write_h, write_w}, {16'd0, 4'd0, 6'd1, 6'd0});
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_write_en", {31'd0, write_en}, 32'd0);
    check("arst_wcoord", {16'd0, write_ch, write_h, write_w}, 32'd0);
    check("arst_flags", {30'd0, dbg_wr_full, dbg_rd_full}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_mode", {31'd0, mode_sel}, 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    swaps0 = swap_cnt;
    push(8'h60); push(8'h61); push(8'h62); push(8'h63);
    in_valid = 1'b0;
    drain(4'b1111, 100);
    check("arst_swaps", 32'(swap_cnt - swaps0), 32'd1);
    check("arst_mode_end", {31'd0, mode_sel}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
